// File: rtl/pipeline_halt_monitor.sv
`default_nettype none
// ============================================================================
// Module      : pipeline_halt_monitor
// Description : Run-control monitor for the pipelined RISC-V core. Watches
//               the writeback retire stream and halts the run on a PC
//               breakpoint, an exhausted cycle budget or a retire-stall
//               watchdog. Reports cause, halting PC, cycle/retire counts and
//               a circular trace of recently retired PCs.
// Ports       : clk, rstn (sync, active-high), enable, resume,
//               pcW_valid/pcW (retire stream), bp_en/bp_addr (breakpoints),
//               cycle_limit, trace_idx -> halt, halt_cause, halt_bp_idx,
//               halt_pc, cycle_count, retire_count, trace_count, trace_pc
// Revision    : 1.0 - initial release
// ============================================================================
module pipeline_halt_monitor #(
    parameter int XLEN        = 32,
    parameter int NUM_BP      = 4,
    parameter int HIST_DEPTH  = 8,
    parameter int STALL_LIMIT = 16,
    parameter int CNT_W       = 32
) (
    input  logic                          clk,
    input  logic                          rstn,
    input  logic                          enable,
    input  logic                          resume,
    input  logic                          pcW_valid,
    input  logic [XLEN-1:0]               pcW,
    input  logic [NUM_BP-1:0]             bp_en,
    input  logic [NUM_BP*XLEN-1:0]        bp_addr,
    input  logic [CNT_W-1:0]              cycle_limit,
    input  logic [$clog2(HIST_DEPTH)-1:0] trace_idx,
    output logic                          halt,
    output logic [1:0]                    halt_cause,
    output logic [3:0]                    halt_bp_idx,
    output logic [XLEN-1:0]               halt_pc,
    output logic [CNT_W-1:0]              cycle_count,
    output logic [CNT_W-1:0]              retire_count,
    output logic [$clog2(HIST_DEPTH):0]   trace_count,
    output logic [XLEN-1:0]               trace_pc
);

    localparam int c_IDX_W   = $clog2(HIST_DEPTH);
    localparam int c_CNT_TW  = c_IDX_W + 1;
    localparam int c_STALL_W = (STALL_LIMIT > 0) ? $clog2(STALL_LIMIT + 1) : 1;

    localparam logic [1:0] c_CAUSE_NONE  = 2'd0;
    localparam logic [1:0] c_CAUSE_BP    = 2'd1;
    localparam logic [1:0] c_CAUSE_CYC   = 2'd2;
    localparam logic [1:0] c_CAUSE_STALL = 2'd3;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_RUN    = 2'd1,
        S_HALTED = 2'd2
    } state_t;

    state_t                r_state;
    state_t                w_state_next;
    logic                  w_start;
    logic                  w_run;
    logic                  w_resume;

    logic [CNT_W-1:0]      r_cycle;
    logic [CNT_W-1:0]      r_retire;
    logic [c_STALL_W-1:0]  r_stall;
    logic [c_CNT_TW-1:0]   r_tcount;
    logic [c_IDX_W-1:0]    r_wptr;
    logic [XLEN-1:0]       r_hist [HIST_DEPTH];
    logic [XLEN-1:0]       r_last_pc;
    logic [1:0]            r_cause;
    logic [3:0]            r_bp_idx;
    logic [XLEN-1:0]       r_halt_pc;

    logic [NUM_BP-1:0]     w_bp_match;
    logic                  w_bp_hit;
    logic [3:0]            w_bp_idx;
    logic [CNT_W-1:0]      w_cycle_inc;
    logic [c_STALL_W-1:0]  w_stall_inc;
    logic                  w_cyc_hit;
    logic                  w_stall_hit;
    logic                  w_trig_any;
    logic [c_IDX_W-1:0]    w_rd_ptr;

    // ---------------------------------------------------------------- triggers
    for (genvar gi = 0; gi < NUM_BP; gi++) begin : g_bp_match
        assign w_bp_match[gi] = pcW_valid && bp_en[gi] &&
                                (pcW == bp_addr[gi*XLEN +: XLEN]);
    end

    // Scan downwards so the lowest matching channel is the one left standing.
    always_comb begin
        w_bp_hit = 1'b0;
        w_bp_idx = 4'd0;
        for (int i = NUM_BP - 1; i >= 0; i--) begin
            if (w_bp_match[i]) begin
                w_bp_hit = 1'b1;
                w_bp_idx = 4'(i);
            end
        end
    end

    assign w_cycle_inc = r_cycle + CNT_W'(1);
    assign w_stall_inc = r_stall + c_STALL_W'(1);
    assign w_cyc_hit   = (cycle_limit != '0) && (w_cycle_inc == cycle_limit);
    assign w_stall_hit = (STALL_LIMIT != 0) && !pcW_valid &&
                         (32'(w_stall_inc) == 32'(STALL_LIMIT));
    assign w_trig_any  = w_bp_hit || w_cyc_hit || w_stall_hit;

    // ---------------------------------------------------------------- FSM
    always_ff @(posedge clk) begin
        if (rstn) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_start      = 1'b0;
        w_run        = 1'b0;
        w_resume     = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (enable) begin
                    w_state_next = S_RUN;
                    w_start      = 1'b1;
                end
            end
            S_RUN: begin
                if (!enable) begin
                    w_state_next = S_IDLE;
                end else begin
                    w_run = 1'b1;
                    if (w_trig_any) begin
                        w_state_next = S_HALTED;
                    end
                end
            end
            S_HALTED: begin
                if (!enable) begin
                    w_state_next = S_IDLE;
                end else if (resume) begin
                    w_state_next = S_RUN;
                    w_resume     = 1'b1;
                end
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

    // ---------------------------------------------------------------- datapath
    always_ff @(posedge clk) begin
        if (rstn) begin
            r_cycle   <= '0;
            r_retire  <= '0;
            r_stall   <= '0;
            r_tcount  <= '0;
            r_wptr    <= '0;
            r_last_pc <= '0;
            r_cause   <= c_CAUSE_NONE;
            r_bp_idx  <= '0;
            r_halt_pc <= '0;
            for (int i = 0; i < HIST_DEPTH; i++) begin
                r_hist[i] <= '0;
            end
        end else if (w_start) begin
            r_cycle  <= '0;
            r_retire <= '0;
            r_stall  <= '0;
            r_tcount <= '0;
            r_wptr   <= '0;
            r_cause  <= c_CAUSE_NONE;
        end else if (w_run) begin
            r_cycle <= w_cycle_inc;
            if (pcW_valid) begin
                r_retire       <= r_retire + CNT_W'(1);
                r_hist[r_wptr] <= pcW;
                r_wptr         <= r_wptr + c_IDX_W'(1);
                if (r_tcount != c_CNT_TW'(HIST_DEPTH)) begin
                    r_tcount <= r_tcount + c_CNT_TW'(1);
                end
                r_stall   <= '0;
                r_last_pc <= pcW;
            end else begin
                r_stall <= w_stall_inc;
            end
            // A retire on the halting edge is already the "last retired PC".
            if (w_bp_hit) begin
                r_cause   <= c_CAUSE_BP;
                r_bp_idx  <= w_bp_idx;
                r_halt_pc <= pcW;
            end else if (w_cyc_hit) begin
                r_cause   <= c_CAUSE_CYC;
                r_halt_pc <= pcW_valid ? pcW : r_last_pc;
            end else if (w_stall_hit) begin
                r_cause   <= c_CAUSE_STALL;
                r_halt_pc <= r_last_pc;
            end
        end else if (w_resume) begin
            r_cause <= c_CAUSE_NONE;
            r_stall <= '0;
        end
    end

    // ---------------------------------------------------------------- outputs
    // Write pointer sits one past the newest entry, so index 0 is wptr-1.
    always_comb begin
        w_rd_ptr = r_wptr - c_IDX_W'(1) - trace_idx;
        trace_pc = '0;
        if ({1'b0, trace_idx} < r_tcount) begin
            trace_pc = r_hist[w_rd_ptr];
        end
    end

    assign halt         = (r_state == S_HALTED);
    assign halt_cause   = r_cause;
    assign halt_bp_idx  = r_bp_idx;
    assign halt_pc      = r_halt_pc;
    assign cycle_count  = r_cycle;
    assign retire_count = r_retire;
    assign trace_count  = r_tcount;

endmodule
`default_nettype wire

// File: tb/tb_pipeline_halt_monitor.sv
`default_nettype none
// ============================================================================
// Module      : tb_pipeline_halt_monitor
// Description : Self-checking bench for pipeline_halt_monitor: a vector
//               table, directed multi-cycle sequences and a randomized run
//               against a queue-based reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pipeline_halt_monitor;

    localparam int XLEN = 32;
    localparam int NBP  = 4;
    localparam int HD   = 8;
    localparam int SL   = 16;
    localparam int CW   = 32;

    logic            clk = 1'b0;
    logic            rstn = 1'b1;
    logic            enable = 1'b0;
    logic            resume = 1'b0;
    logic            pcW_valid = 1'b0;
    logic [XLEN-1:0] pcW = '0;
    logic [NBP-1:0]  bp_en = '0;
    logic [NBP*XLEN-1:0] bp_addr = '0;
    logic [CW-1:0]   cycle_limit = '0;
    logic [2:0]      trace_idx = '0;
    logic            halt;
    logic [1:0]      halt_cause;
    logic [3:0]      halt_bp_idx;
    logic [XLEN-1:0] halt_pc;
    logic [CW-1:0]   cycle_count;
    logic [CW-1:0]   retire_count;
    logic [3:0]      trace_count;
    logic [XLEN-1:0] trace_pc;

    pipeline_halt_monitor #(
        .XLEN(XLEN), .NUM_BP(NBP), .HIST_DEPTH(HD), .STALL_LIMIT(SL), .CNT_W(CW)
    ) dut (
        .clk(clk), .rstn(rstn), .enable(enable), .resume(resume),
        .pcW_valid(pcW_valid), .pcW(pcW), .bp_en(bp_en), .bp_addr(bp_addr),
        .cycle_limit(cycle_limit), .trace_idx(trace_idx),
        .halt(halt), .halt_cause(halt_cause), .halt_bp_idx(halt_bp_idx),
        .halt_pc(halt_pc), .cycle_count(cycle_count), .retire_count(retire_count),
        .trace_count(trace_count), .trace_pc(trace_pc)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_err    = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: actual=0x%0h required=0x%0h", name, act, exp);
        end
    endtask

    // ------------------------------------------------------------ reference model
    // mode: 0 idle, 1 running, 2 halted. Trace kept newest-first in a queue.
    int              m_mode = 0;
    logic [CW-1:0]   m_cyc = '0;
    logic [CW-1:0]   m_ret = '0;
    int              m_stall = 0;
    logic [1:0]      m_cause = 2'd0;
    logic [3:0]      m_bpidx = 4'd0;
    logic [XLEN-1:0] m_hpc = '0;
    logic [XLEN-1:0] m_last = '0;
    logic [XLEN-1:0] m_tr [$];

    task automatic model_step();
        int  hit;
        bit  cyc_hit;
        bit  stall_hit;
        if (rstn) begin
            m_mode = 0; m_cyc = '0; m_ret = '0; m_stall = 0; m_cause = 2'd0;
            m_bpidx = 4'd0; m_hpc = '0; m_last = '0; m_tr.delete();
        end else if (!enable) begin
            m_mode = 0;
        end else if (m_mode == 0) begin
            m_mode = 1; m_cyc = '0; m_ret = '0; m_stall = 0; m_cause = 2'd0;
            m_tr.delete();
        end else if (m_mode == 1) begin
            hit = -1;
            for (int i = 0; i < NBP; i++) begin
                if (hit < 0 && pcW_valid && bp_en[i] && pcW == bp_addr[i*XLEN +: XLEN]) begin
                    hit = i;
                end
            end
            cyc_hit   = (cycle_limit != 0) && (CW'(m_cyc + 1) == cycle_limit);
            stall_hit = !pcW_valid && (m_stall + 1 == SL);
            m_cyc = m_cyc + 1;
            if (pcW_valid) begin
                m_ret = m_ret + 1;
                m_tr.push_front(pcW);
                if (m_tr.size() > HD) void'(m_tr.pop_back());
                m_stall = 0;
                m_last  = pcW;
            end else begin
                m_stall++;
            end
            if (hit >= 0) begin
                m_mode = 2; m_cause = 2'd1; m_bpidx = 4'(hit); m_hpc = pcW;
            end else if (cyc_hit) begin
                m_mode = 2; m_cause = 2'd2; m_hpc = m_last;
            end else if (stall_hit) begin
                m_mode = 2; m_cause = 2'd3; m_hpc = m_last;
            end
        end else if (resume) begin
            m_mode = 1; m_cause = 2'd0; m_stall = 0;
        end
    endtask

    task automatic tick();
        model_step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_model();
        logic [XLEN-1:0] exp_tr;
        exp_tr = (int'(trace_idx) < m_tr.size()) ? m_tr[trace_idx] : '0;
        chk("rnd_halt", halt, (m_mode == 2));
        chk("rnd_cause", halt_cause, m_cause);
        chk("rnd_cycle", cycle_count, m_cyc);
        chk("rnd_retire", retire_count, m_ret);
        chk("rnd_tcount", trace_count, (m_tr.size() > HD) ? HD : m_tr.size());
        chk("rnd_trace_pc", trace_pc, exp_tr);
        if (m_mode == 2) chk("rnd_halt_pc", halt_pc, m_hpc);
        if (m_mode == 2 && m_cause == 2'd1) chk("rnd_bp_idx", halt_bp_idx, m_bpidx);
    endtask

    task automatic do_reset();
        rstn = 1'b1; enable = 1'b0; resume = 1'b0; pcW_valid = 1'b0;
        tick();
        rstn = 1'b0;
    endtask

    task automatic start_run();
        enable = 1'b1; pcW_valid = 1'b0;
        tick();
    endtask

    task automatic retire(input logic [XLEN-1:0] pc);
        pcW_valid = 1'b1; pcW = pc;
        tick();
    endtask

    // ------------------------------------------------------------ vector table
    typedef struct {
        logic        rst, en, res, vld;
        logic [31:0] pc;
        logic        e_halt;
        logic [1:0]  e_cause;
        logic [3:0]  e_idx;
        logic [31:0] e_cyc, e_ret;
    } vec_t;

    vec_t tbl [11];

    initial begin
        int n;
        //        rst   en    res   vld   pc          halt  cause idx  cyc ret
        tbl[0]  = '{1'b1, 1'b0, 1'b0, 1'b0, 32'h0,     1'b0, 2'd0, 4'd0, 0, 0};
        tbl[1]  = '{1'b0, 1'b1, 1'b0, 1'b0, 32'h0,     1'b0, 2'd0, 4'd0, 0, 0};
        tbl[2]  = '{1'b0, 1'b1, 1'b0, 1'b1, 32'h1f8,   1'b0, 2'd0, 4'd0, 1, 1};
        tbl[3]  = '{1'b0, 1'b1, 1'b0, 1'b1, 32'h1fc,   1'b0, 2'd0, 4'd0, 2, 2};
        tbl[4]  = '{1'b0, 1'b1, 1'b0, 1'b1, 32'h200,   1'b1, 2'd1, 4'd2, 3, 3};
        tbl[5]  = '{1'b0, 1'b1, 1'b0, 1'b1, 32'h204,   1'b1, 2'd1, 4'd2, 3, 3};
        tbl[6]  = '{1'b0, 1'b1, 1'b1, 1'b0, 32'h0,     1'b0, 2'd0, 4'd0, 3, 3};
        tbl[7]  = '{1'b0, 1'b1, 1'b0, 1'b1, 32'h208,   1'b0, 2'd0, 4'd0, 4, 4};
        tbl[8]  = '{1'b0, 1'b0, 1'b0, 1'b0, 32'h0,     1'b0, 2'd0, 4'd0, 4, 4};
        tbl[9]  = '{1'b0, 1'b1, 1'b0, 1'b0, 32'h0,     1'b0, 2'd0, 4'd0, 0, 0};
        tbl[10] = '{1'b1, 1'b1, 1'b0, 1'b1, 32'h20c,   1'b0, 2'd0, 4'd0, 0, 0};

        // bp2 and bp3 on the same PC, coinciding with the cycle budget.
        bp_addr[2*XLEN +: XLEN] = 32'h200;
        bp_addr[3*XLEN +: XLEN] = 32'h200;
        bp_en       = 4'b1100;
        cycle_limit = 32'd3;
        for (int i = 0; i < 11; i++) begin
            rstn = tbl[i].rst; enable = tbl[i].en; resume = tbl[i].res;
            pcW_valid = tbl[i].vld; pcW = tbl[i].pc;
            tick();
            chk($sformatf("tbl%0d_halt", i), halt, tbl[i].e_halt);
            chk($sformatf("tbl%0d_cause", i), halt_cause, tbl[i].e_cause);
            chk($sformatf("tbl%0d_cycle", i), cycle_count, tbl[i].e_cyc);
            chk($sformatf("tbl%0d_retire", i), retire_count, tbl[i].e_ret);
            if (tbl[i].e_cause == 2'd1) chk($sformatf("tbl%0d_idx", i), halt_bp_idx, tbl[i].e_idx);
        end
        resume = 1'b0;

        // Breakpoint on the 19th retire.
        bp_en = 4'b0001; bp_addr = '0; bp_addr[0 +: XLEN] = 32'h0c000048;
        cycle_limit = '0; trace_idx = 3'd0;
        do_reset();
        chk("rst_halt_pc", halt_pc, 0);
        chk("rst_tcount", trace_count, 0);
        start_run();
        for (int k = 0; k < 19; k++) begin
            retire(32'h0c000000 + 32'(4 * k));
            if (k == 17) chk("bp_not_early", halt, 1'b0);
        end
        chk("bp_halt", halt, 1'b1);
        chk("bp_cause", halt_cause, 2'd1);
        chk("bp_idx", halt_bp_idx, 4'd0);
        chk("bp_halt_pc", halt_pc, 32'h0c000048);
        chk("bp_retire", retire_count, 19);
        chk("bp_trace0", trace_pc, 32'h0c000048);
        retire(32'h0c00004c);
        chk("bp_frozen_retire", retire_count, 19);

        // Cycle budget of 50 with retires every cycle.
        bp_en = '0; cycle_limit = 32'd50;
        do_reset();
        start_run();
        n = 0;
        for (int k = 1; k <= 60; k++) begin
            retire(32'h1000 + 32'(4 * k));
            if (halt) begin n = k; break; end
        end
        chk("cyc_halt_edge", n, 50);
        chk("cyc_cause", halt_cause, 2'd2);
        chk("cyc_count", cycle_count, 50);
        chk("cyc_retire", retire_count, 50);

        // Stall watchdog after three retires.
        cycle_limit = '0;
        do_reset();
        start_run();
        retire(32'h300); retire(32'h304); retire(32'h308);
        pcW_valid = 1'b0;
        n = 0;
        for (int k = 1; k <= 30; k++) begin
            tick();
            if (halt) begin n = k; break; end
        end
        chk("stall_halt_edge", n, 16);
        chk("stall_cause", halt_cause, 2'd3);
        chk("stall_halt_pc", halt_pc, 32'h308);
        chk("stall_retire", retire_count, 3);

        // Trace wrap, resume, and reset while halted.
        do_reset();
        start_run();
        for (int k = 0; k < 11; k++) retire(32'h100 + 32'(4 * k));
        chk("tr_count", trace_count, 8);
        trace_idx = 3'd0; #1; chk("tr_idx0", trace_pc, 32'h128);
        trace_idx = 3'd7; #1; chk("tr_idx7", trace_pc, 32'h10c);
        trace_idx = 3'd3; #1; chk("tr_idx3", trace_pc, 32'h11c);
        bp_en = 4'b0001; bp_addr[0 +: XLEN] = 32'h12c;
        retire(32'h12c);
        chk("tr_bp_halt", halt, 1'b1);
        chk("tr_bp_retire", retire_count, 12);
        resume = 1'b1; retire(32'h130); resume = 1'b0;
        chk("res_halt", halt, 1'b0);
        chk("res_cause", halt_cause, 2'd0);
        chk("res_cycle", cycle_count, 12);
        chk("res_retire", retire_count, 12);
        retire(32'h134);
        chk("res_cont_cycle", cycle_count, 13);
        chk("res_cont_retire", retire_count, 13);
        bp_addr[0 +: XLEN] = 32'h138;
        retire(32'h138);
        chk("rh_halt_pre", halt, 1'b1);
        rstn = 1'b1; tick();
        chk("rh_halt", halt, 1'b0);
        chk("rh_cause", halt_cause, 2'd0);
        chk("rh_cycle", cycle_count, 0);
        chk("rh_retire", retire_count, 0);
        chk("rh_tcount", trace_count, 0);
        chk("rh_halt_pc", halt_pc, 0);
        chk("rh_trace_pc", trace_pc, 0);
        rstn = 1'b0; pcW_valid = 1'b0; tick();
        chk("rh_run_cycle", cycle_count, 0);
        retire(32'h500);
        chk("rh_run_cycle1", cycle_count, 1);
        chk("rh_run_retire1", retire_count, 1);
        chk("rh_run_halt", halt, 1'b0);

        // Randomized run against the reference model.
        do_reset();
        begin
            int pct;
            pct = 60;
            for (int c = 0; c < 4000; c++) begin
                if (c % 200 == 0) begin
                    case ($urandom_range(0, 2))
                        0: pct = 5;
                        1: pct = 50;
                        default: pct = 90;
                    endcase
                    bp_en = 4'($urandom_range(0, 15));
                    for (int i = 0; i < NBP; i++)
                        bp_addr[i*XLEN +: XLEN] = 32'h400 + 32'(4 * $urandom_range(0, 63));
                    cycle_limit = ($urandom_range(0, 3) == 0) ? '0 : 32'($urandom_range(1, 400));
                end
                rstn      = ($urandom_range(0, 299) == 0);
                enable    = ($urandom_range(0, 99) >= 3);
                resume    = ($urandom_range(0, 9) == 0);
                pcW_valid = ($urandom_range(0, 99) < pct);
                pcW       = 32'h400 + 32'(4 * $urandom_range(0, 63));
                trace_idx = 3'($urandom_range(0, 7));
                tick();
                check_model();
            end
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/pipeline_halt_monitor.md
Name: pipeline_halt_monitor

Overview:
- Synthesizable run-control monitor for the pipelined RISC-V core; observes the writeback-stage retire stream (pcW).
- Stops the run on any of: N programmable PC breakpoints, a cycle budget, or a retire-stall watchdog.
- Reports halt cause, halting PC, cycle and retire counts, and a circular trace of recent retired PCs.
- Sits beside the core in the top-level wrapper; halt gates the core clock-enable or the bench.

Parameters:
XLEN, 32, PC width
NUM_BP, 4, breakpoint comparator channels (1..16)
HIST_DEPTH, 8, trace buffer entries (power of two, 2..64)
STALL_LIMIT, 16, consecutive non-retire RUN cycles before stall halt; 0 disables
CNT_W, 32, width of cycle and retire counters

Ports:
clk  in  1  clock, all logic rising-edge
rstn  in  1  reset, synchronous, active-high (port keeps codebase name)
enable  in  1  1 = monitor active
resume  in  1  leave HALTED, continue run
pcW_valid  in  1  an instruction retires this cycle
pcW  in  XLEN  PC of retiring instruction
bp_en  in  NUM_BP  per-channel breakpoint enable
bp_addr  in  NUM_BP*XLEN  channel i at bits [i*XLEN +: XLEN]
cycle_limit  in  CNT_W  cycle budget; 0 disables
trace_idx  in  log2(HIST_DEPTH)  0 = most recent retire
halt  out  1  high while in HALTED
halt_cause  out  2  0 none, 1 breakpoint, 2 cycle limit, 3 stall
halt_bp_idx  out  4  lowest matching channel (valid when cause=1)
halt_pc  out  XLEN  pcW at breakpoint/last retired PC otherwise
cycle_count  out  CNT_W  RUN cycles elapsed
retire_count  out  CNT_W  retires counted in RUN
trace_count  out  log2(HIST_DEPTH)+1  valid trace entries, saturates at HIST_DEPTH
trace_pc  out  XLEN  trace entry at trace_idx (combinational read), 0 if idx >= trace_count

Behaviour:
- Reset (rstn=1 at edge): state IDLE; every output and internal counter/pointer 0; trace contents 0. Reset overrides all other inputs, including mid-RUN or HALTED.
- States IDLE, RUN, HALTED. enable=0 at an edge -> IDLE from any state (halt drops, counters hold).
- IDLE -> RUN when enable=1: same edge clears cycle_count, retire_count, stall counter, trace_count, trace pointer, halt_cause.
- RUN per edge: cycle_count+1; if pcW_valid: retire_count+1, pcW written to trace (pointer wraps modulo HIST_DEPTH, trace_count saturates), stall counter := 0, last PC := pcW; else stall counter+1.
- Halt evaluated on the same RUN edge; state -> HALTED, halt=1 after that edge (one-cycle latency from the triggering input):
  - breakpoint: pcW_valid and bp_en[i] and pcW==bp_addr[i]; the matching retire is still counted and traced; halt_pc=pcW.
  - cycle limit: cycle_limit!=0 and cycle_count+1 == cycle_limit.
  - stall: STALL_LIMIT!=0 and stall counter+1 == STALL_LIMIT with no retire.
- Simultaneous triggers: priority breakpoint > cycle limit > stall; among channels the lowest index wins.
- HALTED: all counters, trace, and halt_* fields frozen; retires ignored. resume=1 (enable=1) -> RUN next edge: halt=0, halt_cause=0, stall counter=0; cycle/retire counts continue (limit re-triggers only on counter wrap).
- Counters wrap modulo 2^CNT_W without flagging.

Test Plan:
- Reset, enable=1, bp0=0x0c000048 enabled, retire 0x0c000000..0x0c000048 step 4 each cycle -> halt after the 19th-retire edge, cause=1, idx=0, halt_pc=0x0c000048, retire_count=19, trace_pc[0]=0x0c000048.
- cycle_limit=50, no breakpoints, retire every cycle -> halt after 50 RUN edges, cause=2, cycle_count=50, retire_count=50.
- STALL_LIMIT=16, 3 retires then pcW_valid=0 -> halt after 16 idle edges, cause=3, halt_pc=third PC, retire_count=3.
- bp2 and bp3 both match on the cycle cycle_count reaches cycle_limit -> cause=1, idx=2.
- HIST_DEPTH=8, 11 retires of PCs 0x100+4k -> trace_count=8, trace_pc[idx 0]=0x128, idx 7=0x10c; resume after halt -> halt=0 next cycle, counts continue.
- rstn=1 mid-RUN and while HALTED -> next cycle all outputs 0, state IDLE; enable still high -> RUN following edge with cleared counters.
